// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Holds the FSM encoding, legal oversampling ratios and parity helpers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;
    localparam int DATA_WIDTH  = 8;
    localparam int BIT_CNT_W   = 4;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    function automatic logic is_legal_prescale(input logic [31:0] val);
        return (val == 32'(PRESCALE_8)) || (val == 32'(PRESCALE_16)) ||
               (val == 32'(PRESCALE_32));
    endfunction

    function automatic logic parity_update(input logic acc, input logic data_bit);
        return acc ^ data_bit;
    endfunction

    // Parity bit the transmitter should have sent: even -> acc, odd -> ~acc.
    function automatic logic parity_expected(input logic acc, input logic par_typ);
        return acc ^ par_typ;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data-bit counter for the UART receiver.
// The edge index runs 0..scale-1 while enabled and rests at 0 otherwise.
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int scale_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_cnt_en,
    input  logic [scale_WIDTH-1:0] i_scale,
    input  logic                   i_bit_clr,
    input  logic                   i_bit_inc,
    output logic [scale_WIDTH-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]   o_bit_cnt,
    output logic                   o_bit_end
);

    logic [scale_WIDTH-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic                   w_last_edge;

    assign w_last_edge = (r_edge_cnt == (i_scale - scale_WIDTH'(1)));

    // Edge index within the current bit period, wrapping at scale-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cnt <= {scale_WIDTH{1'b0}};
        end else if (!i_cnt_en) begin
            r_edge_cnt <= {scale_WIDTH{1'b0}};
        end else if (w_last_edge) begin
            r_edge_cnt <= {scale_WIDTH{1'b0}};
        end else begin
            r_edge_cnt <= r_edge_cnt + scale_WIDTH'(1);
        end
    end

    // Data-bit index, cleared at frame start and advanced per received bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= {BIT_CNT_W{1'b0}};
        end else if (i_bit_clr) begin
            r_bit_cnt <= {BIT_CNT_W{1'b0}};
        end else if (i_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end else begin
            r_bit_cnt <= r_bit_cnt;
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;
    assign o_bit_end  = i_cnt_en & w_last_edge;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames start/data/parity/stop bits from an
// oversampled line and reports deserializer strobes and frame status pulses.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int scale_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   RX_IN,
    input  logic [scale_WIDTH-1:0] prescaler,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic                   sampled_bit,
    output logic                   dat_samp_en,
    output logic [scale_WIDTH-1:0] edge_cnt,
    output logic [3:0]             bit_cnt,
    output logic                   deser_en,
    output logic                   data_valid,
    output logic                   par_err,
    output logic                   stp_err,
    output logic                   strt_glitch,
    output logic                   busy
);

    rx_state_e              r_state;
    rx_state_e              w_next_state;
    logic [scale_WIDTH-1:0] r_scale;
    logic                   r_par_acc;
    logic                   r_par_fail;
    logic                   r_deser_en;
    logic                   r_data_valid;
    logic                   r_par_err;
    logic                   r_stp_err;
    logic                   r_strt_glitch;

    logic                   w_busy;
    logic                   w_bit_end;
    logic                   w_presc_legal;
    logic                   w_latch_scale;
    logic                   w_bit_clr;
    logic                   w_bit_inc;
    logic                   w_par_acc_next;
    logic                   w_par_fail_next;
    logic                   w_deser_next;
    logic                   w_valid_next;
    logic                   w_par_err_next;
    logic                   w_stp_err_next;
    logic                   w_glitch_next;
    logic [scale_WIDTH-1:0] w_edge_cnt;
    logic [BIT_CNT_W-1:0]   w_bit_cnt;

    assign w_busy        = (r_state != ST_IDLE);
    assign w_presc_legal = is_legal_prescale(32'(prescaler));

    uart_rx_edge_bit_cnt #(
        .scale_WIDTH (scale_WIDTH)
    ) u_edge_bit_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_cnt_en   (w_busy),
        .i_scale    (r_scale),
        .i_bit_clr  (w_bit_clr),
        .i_bit_inc  (w_bit_inc),
        .o_edge_cnt (w_edge_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_bit_end  (w_bit_end)
    );

    // State register and registered frame bookkeeping / status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_scale       <= scale_WIDTH'(PRESCALE_8);
            r_par_acc     <= 1'b0;
            r_par_fail    <= 1'b0;
            r_deser_en    <= 1'b0;
            r_data_valid  <= 1'b0;
            r_par_err     <= 1'b0;
            r_stp_err     <= 1'b0;
            r_strt_glitch <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_scale       <= w_latch_scale ? prescaler : r_scale;
            r_par_acc     <= w_par_acc_next;
            r_par_fail    <= w_par_fail_next;
            r_deser_en    <= w_deser_next;
            r_data_valid  <= w_valid_next;
            r_par_err     <= w_par_err_next;
            r_stp_err     <= w_stp_err_next;
            r_strt_glitch <= w_glitch_next;
        end
    end

    // Next-state and next-pulse decode; every decision waits for bit end.
    always_comb begin
        w_next_state    = r_state;
        w_latch_scale   = 1'b0;
        w_bit_clr       = 1'b0;
        w_bit_inc       = 1'b0;
        w_par_acc_next  = r_par_acc;
        w_par_fail_next = r_par_fail;
        w_deser_next    = 1'b0;
        w_valid_next    = 1'b0;
        w_par_err_next  = 1'b0;
        w_stp_err_next  = 1'b0;
        w_glitch_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN && w_presc_legal) begin
                    w_next_state    = ST_START;
                    w_latch_scale   = 1'b1;
                    w_bit_clr       = 1'b1;
                    w_par_acc_next  = 1'b0;
                    w_par_fail_next = 1'b0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end && !sampled_bit) begin
                    w_next_state = ST_DATA;
                end else if (w_bit_end) begin
                    w_glitch_next = 1'b1;
                    w_next_state  = ST_IDLE;
                end else begin
                    w_next_state = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_deser_next   = 1'b1;
                    w_bit_inc      = 1'b1;
                    w_par_acc_next = parity_update(r_par_acc, sampled_bit);
                    if (w_bit_cnt == LAST_BIT) begin
                        w_next_state = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = ST_STOP;
                    if (sampled_bit != parity_expected(r_par_acc, PAR_TYP)) begin
                        w_par_err_next  = 1'b1;
                        w_par_fail_next = 1'b1;
                    end else begin
                        w_par_fail_next = r_par_fail;
                    end
                end else begin
                    w_next_state = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    w_next_state   = ST_IDLE;
                    w_stp_err_next = ~sampled_bit;
                    w_valid_next   = sampled_bit & ~r_par_fail;
                end else begin
                    w_next_state = ST_STOP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign busy        = w_busy;
    assign dat_samp_en = w_busy;
    assign edge_cnt    = w_edge_cnt;
    assign bit_cnt     = w_bit_cnt;
    assign deser_en    = r_deser_en;
    assign data_valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign strt_glitch = r_strt_glitch;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a table of frames plus hand-written
// corner sequences, with pulse timing checked against a scoreboard queue.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       RX_IN;
    logic [5:0] prescaler;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       deser_en;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;
    logic       busy;

    uart_rx_ctrl #(.scale_WIDTH(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .RX_IN       (RX_IN),
        .prescaler   (prescaler),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .deser_en    (deser_en),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         p;
        bit         par_en;
        bit         par_typ;
        logic [7:0] data;
        bit         par_bit;
        bit         stop_bit;
        bit         start_bit;
        int         rx_low;
        bit         exp_valid;
        bit         exp_perr;
        bit         exp_serr;
        bit         exp_glitch;
    } vec_t;

    // Pulse kinds: 0 deser_en, 1 data_valid, 2 par_err, 3 stp_err, 4 strt_glitch
    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    vec_t vt[8];
    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare any status pulse against the scoreboard at negedge.
    task automatic tick();
        logic [4:0] pulses;
        exp_t       e;
        @(negedge clk);
        pulses = {strt_glitch, stp_err, par_err, data_valid, deser_en};
        for (int k = 0; k < 5; k++) begin
            if (pulses[k]) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.cyc != cyc) begin
                        n_miss++;
                        $display("FAIL pulse: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic push_exp(input int kind, input int off, input int t0, input int abort);
        if (abort < 0 || off < abort) begin
            exp_q.push_back('{kind: kind, cyc: t0 + off});
        end
    endtask

    // Drive one frame; abort >= 0 stops driving that many cycles after the start edge.
    task automatic run_frame(input vec_t v, input int abort);
        logic bits[11];
        int   nb;
        int   t0;
        int   stop_off;
        bits[0] = v.start_bit;
        for (int i = 0; i < 8; i++) bits[i+1] = v.data[i];
        nb = 9;
        if (v.par_en) begin
            bits[9] = v.par_bit;
            nb = 10;
        end
        bits[nb] = v.stop_bit;
        nb = nb + 1;
        if (v.start_bit) nb = 1;
        stop_off = nb * v.p;

        prescaler = 6'(v.p);
        PAR_EN    = v.par_en;
        PAR_TYP   = v.par_typ;
        RX_IN     = 1'b0;
        tick();
        t0 = cyc;

        if (v.start_bit) begin
            if (v.exp_glitch) push_exp(4, v.p, t0, abort);
        end else begin
            for (int i = 0; i < 8; i++) push_exp(0, (i + 2) * v.p, t0, abort);
            if (v.par_en && v.exp_perr) push_exp(2, 10 * v.p, t0, abort);
            if (v.exp_serr)  push_exp(3, stop_off, t0, abort);
            if (v.exp_valid) push_exp(1, stop_off, t0, abort);
        end

        for (int k = 0; k < stop_off; k++) begin
            if (k == abort) return;
            sampled_bit = bits[k / v.p];
            RX_IN = (k < v.rx_low - 1) ? 1'b0 : 1'b1;
            if (k % v.p == v.p - 1) begin
                chk("edge_cnt_at_bit_end", int'(edge_cnt), v.p - 1);
                chk("busy_in_frame", int'(busy), 1);
                chk("dat_samp_en_in_frame", int'(dat_samp_en), 1);
            end
            if (!v.start_bit && k > 0 && k <= 8 * v.p && k % v.p == 0) begin
                chk("bit_cnt", int'(bit_cnt), k / v.p - 1);
            end
            tick();
        end
        sampled_bit = 1'b1;
        chk("busy_after_frame", int'(busy), 0);
        chk("edge_cnt_after_frame", int'(edge_cnt), 0);
        tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic int all_outputs();
        return int'({dat_samp_en, edge_cnt, bit_cnt, deser_en, data_valid,
                     par_err, stp_err, strt_glitch, busy});
    endfunction

    initial begin
        //       p  pen ptyp data   pbit stop start rxlow valid perr serr glitch
        vt[0] = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 8,  1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2] = '{16, 1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 16, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[3] = '{32, 1'b1, 1'b1, 8'hA7, 1'b0, 1'b1, 1'b0, 32, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[4] = '{8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 8,  1'b0, 1'b0, 1'b1, 1'b0};
        vt[5] = '{32, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[6] = '{32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7] = '{8,  1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0, 8,  1'b1, 1'b0, 1'b0, 1'b0};

        reset_n     = 1'b0;
        RX_IN       = 1'b0;
        prescaler   = 6'd8;
        PAR_EN      = 1'b0;
        PAR_TYP     = 1'b0;
        sampled_bit = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) begin
            tick();
            chk("reset_outputs_low", all_outputs(), 0);
        end
        RX_IN   = 1'b1;
        reset_n = 1'b1;
        tick();
        chk("idle_after_reset", int'(busy), 0);

        for (int i = 0; i < 8; i++) run_frame(vt[i], -1);

        // Illegal oversampling ratio must never start a frame.
        prescaler = 6'd12;
        RX_IN     = 1'b0;
        repeat (20) begin
            tick();
            chk("illegal_prescale_busy", int'(busy), 0);
            chk("illegal_prescale_edge", int'(edge_cnt), 0);
        end
        RX_IN = 1'b1;
        tick();

        // Reset asserted three clocks into data bit 4, then a clean frame.
        run_frame(vt[0], 43);
        chk("busy_before_abort", int'(busy), 1);
        chk("bit_cnt_before_abort", int'(bit_cnt), 4);
        reset_n = 1'b0;
        RX_IN   = 1'b1;
        #1;
        chk("midframe_reset_outputs", all_outputs(), 0);
        repeat (2) begin
            tick();
            chk("midframe_reset_hold", all_outputs(), 0);
        end
        reset_n = 1'b1;
        tick();
        chk("scoreboard_after_abort", exp_q.size(), 0);
        chk("idle_after_abort", int'(busy), 0);
        run_frame(vt[0], -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter: scale_WIDTH, 6, width of prescaler and edge_cnt.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: RX_IN  input  1  serial line, idle high.
REQ-005 SHALL have port: prescaler  input  scale_WIDTH  oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port: PAR_EN  input  1  parity bit present when 1.
REQ-007 SHALL have port: PAR_TYP  input  1  0 = even, 1 = odd.
REQ-008 SHALL have port: sampled_bit  input  1  majority bit from the sampling stage.
REQ-009 SHALL have port: dat_samp_en  output  1  sampling-stage enable.
REQ-010 SHALL have port: edge_cnt  output  scale_WIDTH  oversampling edge index within the current bit.
REQ-011 SHALL have port: bit_cnt  output  4  data bit index, 0..7.
REQ-012 SHALL have port: deser_en  output  1  one-cycle strobe to shift sampled_bit into the deserializer.
REQ-013 SHALL have port: data_valid  output  1  one-cycle frame-good pulse.
REQ-014 SHALL have port: par_err  output  1  one-cycle parity-error pulse.
REQ-015 SHALL have port: stp_err  output  1  one-cycle stop-error pulse.
REQ-016 SHALL have port: strt_glitch  output  1  one-cycle false-start pulse.
REQ-017 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-019 SHALL leave IDLE for START on the first clock where RX_IN = 0 and prescaler is legal; with an illegal prescaler it SHALL stay in IDLE.
REQ-020 SHALL latch prescaler into P on the IDLE->START transition and use P for the rest of the frame.
REQ-021 SHALL hold edge_cnt at 0 in IDLE, increment it by 1 per clock in other states, and wrap it P-1 -> 0.
REQ-022 SHALL define "bit end" as the cycle with edge_cnt = P-1; every decision, strobe and state change SHALL occur at bit end only.
REQ-023 SHALL drive dat_samp_en = busy.
REQ-024 SHALL, at START bit end, go to DATA with bit_cnt = 0 when sampled_bit = 0; otherwise it SHALL pulse strt_glitch and return to IDLE.
REQ-025 SHALL, at each DATA bit end, pulse deser_en, XOR sampled_bit into the running parity, and increment bit_cnt.
REQ-026 SHALL leave DATA at the bit end where bit_cnt = 7, going to PARITY if PAR_EN = 1 and to STOP otherwise.
REQ-027 SHALL, at PARITY bit end, pulse par_err when sampled_bit != (running parity XOR PAR_TYP), then go to STOP.
REQ-028 SHALL record the parity result for the frame.
REQ-029 SHALL, at STOP bit end, pulse stp_err when sampled_bit = 0.
REQ-030 SHALL, at STOP bit end, pulse data_valid when sampled_bit = 1 and no parity error was recorded for the frame.
REQ-031 SHALL go to IDLE after STOP bit end.
REQ-032 SHALL sample PAR_EN and PAR_TYP at use, with no latching.
REQ-033 SHALL drive deser_en, data_valid, par_err, stp_err and strt_glitch as registered pulses exactly one cycle wide, all low otherwise.
REQ-034 SHALL clear bit_cnt and the running parity on entry to START.
REQ-035 SHALL ignore RX_IN except in IDLE.

Reset
REQ-036 SHALL, while reset_n = 0, force state IDLE, edge_cnt = 0, bit_cnt = 0, running parity = 0, and P = 8.
REQ-037 SHALL, while reset_n = 0, hold all outputs low.
REQ-038 SHALL abandon any frame in progress when reset is asserted mid-frame, with no pulse emitted.
REQ-039 SHALL leave reset into IDLE.

Structure
REQ-040 SHALL place the FSM state encoding, the legal prescaler constants (8/16/32) and the data width (8) in the shared package uart_rx_pkg.
REQ-041 SHALL implement the edge/bit counter pair as the single sub-module uart_rx_edge_bit_cnt.

Verification
REQ-042 SHALL cover: P=8, PAR_EN=0, frame 0x55 with stop=1 -> 8 deser_en pulses, data_valid at STOP edge 7, frame length 80 clocks.
REQ-043 SHALL cover: P=16, PAR_EN=1, PAR_TYP=0, data 0x03, parity bit 1 -> par_err pulse, no data_valid.
REQ-044 SHALL cover: P=32, low on RX_IN for 10 clocks then high -> strt_glitch at edge 31, return to IDLE, no deser_en.
REQ-045 SHALL cover: P=8, stop bit 0 -> stp_err, no data_valid.
REQ-046 SHALL cover: prescaler = 12 with RX_IN low -> busy stays 0.
REQ-047 SHALL cover: reset_n pulsed low during DATA bit 4 -> all outputs 0, IDLE, and the next frame decodes correctly.
